// File: rtl/pico_port_fifo_responder_pkg.sv
// Shared PicoBlaze I/O constants: default port map, STATUS/CTRL bit positions, control register layout.
// Pure declarations; no latency or backpressure of its own.
package pico_io_pkg;

   localparam logic [7:0] DATA_PORT_DEF   = 8'h08;
   localparam logic [7:0] STATUS_PORT_DEF = 8'h09;
   localparam logic [7:0] COUNT_PORT_DEF  = 8'h0A;
   localparam logic [7:0] CTRL_PORT_DEF   = 8'h0B;

   localparam int ST_FULL  = 7;
   localparam int ST_EMPTY = 6;
   localparam int ST_OVF   = 5;
   localparam int ST_IRQ   = 4;

   localparam int CT_IRQ_EN = 7;
   localparam int CT_FLUSH  = 6;
   localparam int CT_LW_MSB = 5;

   localparam logic [7:0] UNMAPPED_RD = 8'h00;

   typedef struct packed {
      logic       irq_en;
      logic       flush;
      logic [5:0] low_water;
   } ctrl_t;

   typedef enum logic {
      IRQ_IDLE,
      IRQ_PEND
   } irq_state_t;

   // A threshold the FIFO can never drop to would silently disable the interrupt.
   function automatic logic [5:0] clamp_lw(input logic [5:0] lw, input int depth);
      return (int'(lw) >= depth) ? 6'(depth - 1) : lw;
   endfunction

endpackage

// File: rtl/pico_port_fifo_responder_if.sv
// PicoBlaze port bus plus the drain-side byte stream of the FIFO responder.
// slave = peripheral side, master = processor/consumer side; stream uses valid/ready.
interface pico_port_fifo_responder_if;

   logic [7:0] port_id;
   logic [7:0] out_port;
   logic       write_strobe;
   logic       read_strobe;
   logic [7:0] in_port;
   logic       interrupt;
   logic       interrupt_ack;
   logic [7:0] dout;
   logic       dout_valid;
   logic       dout_ready;

   modport slave (
      input  port_id, out_port, write_strobe, read_strobe, interrupt_ack, dout_ready,
      output in_port, interrupt, dout, dout_valid
   );

   modport master (
      output port_id, out_port, write_strobe, read_strobe, interrupt_ack, dout_ready,
      input  in_port, interrupt, dout, dout_valid
   );

endinterface

// File: rtl/pico_byte_fifo.sv
// Show-ahead byte FIFO with flush; push visible on dout one cycle later, head byte shown combinationally.
// Pushes while full are ignored (caller flags overflow); flush beats push/pop in the same cycle.
module pico_byte_fifo #(
   parameter  int DEPTH = 16,
   localparam int AW    = $clog2(DEPTH),
   localparam int CW    = AW + 1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          push,
   input  logic [7:0]    push_dat,
   input  logic          pop,
   input  logic          flush,
   output logic [7:0]    dout,
   output logic          dout_vld,
   output logic [CW-1:0] count,
   output logic          full,
   output logic          empty
);

   logic [7:0]    mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [CW-1:0] count_nxt;
   logic          push_ok;
   logic          pop_ok;

   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign push_ok = push & ~full;
   assign pop_ok  = pop & dout_vld;
   // Gate the head so an unwritten (unreset) slot never leaks X onto dout.
   assign dout    = dout_vld ? mem[rd_ptr] : 8'h00;

   always_comb begin
      count_nxt = count;
      if (flush)
         count_nxt = '0;
      else if (push_ok && !pop_ok)
         count_nxt = count + 1'b1;
      else if (!push_ok && pop_ok)
         count_nxt = count - 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         dout_vld <= 1'b0;
      end else begin
         count    <= count_nxt;
         dout_vld <= (count_nxt != '0);
         if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
         end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok && !flush)
         mem[wr_ptr] <= push_dat;
   end

endmodule

// File: rtl/pico_port_fifo_responder.sv
// PicoBlaze port-mapped byte FIFO with status/count/ctrl readback and low-water interrupt; reads 1-cycle registered.
// Consumer drains via dout_valid/dout_ready; writes to a full FIFO are dropped and set sticky overflow. Macro: PICO_ONEHOT_DECODE_EN.
module pico_port_fifo_responder
   import pico_io_pkg::*;
#(
   parameter int         DEPTH       = 16,
   parameter logic [7:0] DATA_PORT   = DATA_PORT_DEF,
   parameter logic [7:0] STATUS_PORT = STATUS_PORT_DEF,
   parameter logic [7:0] COUNT_PORT  = COUNT_PORT_DEF,
   parameter logic [7:0] CTRL_PORT   = CTRL_PORT_DEF
) (
   input  logic                         clk,
   input  logic                         reset_n,
   pico_port_fifo_responder_if.slave    io
);

   localparam int CW = $clog2(DEPTH) + 1;

   logic          data_wr;
   logic          ctrl_wr;
   logic          status_rd;
   logic          flush;
   logic          push_ok;
   logic          pop_fire;
   logic          crossing;
   logic          irq_en_nxt;
   logic          full;
   logic          empty;
   logic          fifo_vld;
   logic [CW-1:0] count;
   logic          ovf_q;
   ctrl_t         ctrl_q;
   irq_state_t    irq_state;
   logic          irq_q;
   logic [7:0]    in_port_q;
   logic [7:0]    status_byte;

`ifdef PICO_ONEHOT_DECODE_EN
   assign data_wr = io.write_strobe & |(io.port_id & DATA_PORT);
   assign ctrl_wr = io.write_strobe & |(io.port_id & CTRL_PORT);
`else
   assign data_wr = io.write_strobe & (io.port_id == DATA_PORT);
   assign ctrl_wr = io.write_strobe & (io.port_id == CTRL_PORT);
`endif

   assign status_rd  = io.read_strobe & (io.port_id == STATUS_PORT);
   assign flush      = ctrl_wr & io.out_port[CT_FLUSH];
   assign push_ok    = data_wr & ~full;
   assign pop_fire   = fifo_vld & io.dout_ready;
   assign irq_en_nxt = ctrl_wr ? io.out_port[CT_IRQ_EN] : ctrl_q.irq_en;
   // Only a pure pop lands count exactly on low_water from above.
   assign crossing   = ctrl_q.irq_en & pop_fire & ~push_ok & ~flush &
                       (int'(count) == int'(ctrl_q.low_water) + 1);

   pico_byte_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk      (clk),
      .rst_n    (reset_n),
      .push     (data_wr),
      .push_dat (io.out_port),
      .pop      (io.dout_ready),
      .flush    (flush),
      .dout     (io.dout),
      .dout_vld (fifo_vld),
      .count    (count),
      .full     (full),
      .empty    (empty)
   );

   assign io.dout_valid = fifo_vld;
   assign io.in_port    = in_port_q;
   assign io.interrupt  = irq_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ctrl_q <= '0;
         ovf_q  <= 1'b0;
      end else begin
         if (ctrl_wr) begin
            ctrl_q.irq_en    <= io.out_port[CT_IRQ_EN];
            ctrl_q.flush     <= 1'b0;
            ctrl_q.low_water <= clamp_lw(io.out_port[CT_LW_MSB:0], DEPTH);
         end
         ovf_q <= (data_wr & full) | (ovf_q & ~status_rd);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         irq_state <= IRQ_IDLE;
         irq_q     <= 1'b0;
      end else if (!irq_en_nxt) begin
         irq_state <= IRQ_IDLE;
         irq_q     <= 1'b0;
      end else begin
         case (irq_state)
            IRQ_IDLE: begin
               if (crossing) begin
                  irq_state <= IRQ_PEND;
                  irq_q     <= 1'b1;
               end
            end
            IRQ_PEND: begin
               if (io.interrupt_ack && !crossing) begin
                  irq_state <= IRQ_IDLE;
                  irq_q     <= 1'b0;
               end
            end
            default: begin
               irq_state <= IRQ_IDLE;
               irq_q     <= 1'b0;
            end
         endcase
      end
   end

   always_comb begin
      status_byte           = 8'h00;
      status_byte[ST_FULL]  = full;
      status_byte[ST_EMPTY] = empty;
      status_byte[ST_OVF]   = ovf_q;
      status_byte[ST_IRQ]   = irq_q;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         in_port_q <= 8'h00;
      end else begin
         case (io.port_id)
            STATUS_PORT: in_port_q <= status_byte;
            COUNT_PORT:  in_port_q <= 8'(count);
            CTRL_PORT:   in_port_q <= ctrl_q;
            default:     in_port_q <= UNMAPPED_RD;
         endcase
      end
   end

endmodule

// File: tb/tb_pico_port_fifo_responder.sv
// Bench for pico_port_fifo_responder: table of single-cycle vectors, then directed multi-cycle sequences.
module tb_pico_port_fifo_responder;
   import pico_io_pkg::*;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   int   tests = 0;
   int   fails = 0;

   pico_port_fifo_responder_if bus();

   pico_port_fifo_responder #(.DEPTH(16)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .io      (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       wr;
      logic       rd;
      logic       rdy;
      logic [7:0] port;
      logic [7:0] data;
      logic [7:0] exp_in;
      logic       exp_vld;
      logic [7:0] exp_dout;
   } vec_t;

   vec_t vt[11];

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %02h want %02h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [7:0] p, input logic [7:0] d);
      bus.port_id      = p;
      bus.out_port     = d;
      bus.write_strobe = 1'b1;
      tick();
      bus.write_strobe = 1'b0;
   endtask

   task automatic rd(input string n, input logic [7:0] p, input logic [7:0] exp);
      bus.port_id     = p;
      bus.read_strobe = 1'b1;
      tick();
      bus.read_strobe = 1'b0;
      chk(n, bus.in_port, exp);
   endtask

   task automatic pop1();
      bus.dout_ready = 1'b1;
      tick();
      bus.dout_ready = 1'b0;
   endtask

   initial begin
      bus.port_id       = 8'h00;
      bus.out_port      = 8'h00;
      bus.write_strobe  = 1'b0;
      bus.read_strobe   = 1'b0;
      bus.interrupt_ack = 1'b0;
      bus.dout_ready    = 1'b0;

      // wr rd rdy port data -> in_port dout_valid dout
      vt[0]  = '{1'b0, 1'b1, 1'b0, 8'h09, 8'h00, 8'h40, 1'b0, 8'h00};
      vt[1]  = '{1'b0, 1'b1, 1'b0, 8'h0A, 8'h00, 8'h00, 1'b0, 8'h00};
      vt[2]  = '{1'b0, 1'b1, 1'b0, 8'h0B, 8'h00, 8'h00, 1'b0, 8'h00};
      vt[3]  = '{1'b0, 1'b1, 1'b0, 8'h55, 8'h00, 8'h00, 1'b0, 8'h00};
      vt[4]  = '{1'b1, 1'b0, 1'b0, 8'h08, 8'hA5, 8'h00, 1'b1, 8'hA5};
      vt[5]  = '{1'b1, 1'b0, 1'b0, 8'h08, 8'h3C, 8'h00, 1'b1, 8'hA5};
      vt[6]  = '{1'b0, 1'b1, 1'b0, 8'h0A, 8'h00, 8'h02, 1'b1, 8'hA5};
      vt[7]  = '{1'b0, 1'b0, 1'b1, 8'h55, 8'h00, 8'h00, 1'b1, 8'h3C};
      vt[8]  = '{1'b0, 1'b0, 1'b1, 8'h55, 8'h00, 8'h00, 1'b0, 8'h00};
      vt[9]  = '{1'b0, 1'b1, 1'b0, 8'h0A, 8'h00, 8'h00, 1'b0, 8'h00};
      vt[10] = '{1'b0, 1'b1, 1'b0, 8'h09, 8'h00, 8'h40, 1'b0, 8'h00};

      #2;
      chk("rst in_port", bus.in_port, 8'h00);
      chk("rst interrupt", {7'b0, bus.interrupt}, 8'h00);
      chk("rst dout_valid", {7'b0, bus.dout_valid}, 8'h00);
      chk("rst dout", bus.dout, 8'h00);
      #10 reset_n = 1'b1;
      tick();

      for (int i = 0; i < 11; i++) begin
         bus.write_strobe = vt[i].wr;
         bus.read_strobe  = vt[i].rd;
         bus.dout_ready   = vt[i].rdy;
         bus.port_id      = vt[i].port;
         bus.out_port     = vt[i].data;
         tick();
         bus.write_strobe = 1'b0;
         bus.read_strobe  = 1'b0;
         bus.dout_ready   = 1'b0;
         chk($sformatf("vec%0d in_port", i), bus.in_port, vt[i].exp_in);
         chk($sformatf("vec%0d dout_valid", i), {7'b0, bus.dout_valid}, {7'b0, vt[i].exp_vld});
         chk($sformatf("vec%0d dout", i), bus.dout, vt[i].exp_dout);
      end

      // Overfill: 17th byte dropped, overflow sticky until STATUS read.
      for (int i = 0; i < 17; i++) wr(8'h08, 8'(8'h10 + i));
      rd("full count", 8'h0A, 8'h10);
      rd("full status", 8'h09, 8'hA0);
      rd("status after clear", 8'h09, 8'h80);
      for (int k = 0; k < 16; k++) begin
         chk($sformatf("drain%0d dout", k), bus.dout, 8'(8'h10 + k));
         pop1();
      end
      chk("drained valid", {7'b0, bus.dout_valid}, 8'h00);
      chk("drained dout", bus.dout, 8'h00);

      // Low-water interrupt on downward crossing 3->2.
      wr(8'h0B, 8'h82);
      rd("ctrl 82", 8'h0B, 8'h82);
      for (int i = 0; i < 4; i++) wr(8'h08, 8'(8'hC0 + i));
      pop1();
      chk("irq at 3", {7'b0, bus.interrupt}, 8'h00);
      pop1();
      chk("irq at 2", {7'b0, bus.interrupt}, 8'h01);
      bus.interrupt_ack = 1'b1;
      tick();
      bus.interrupt_ack = 1'b0;
      chk("irq acked", {7'b0, bus.interrupt}, 8'h00);
      wr(8'h08, 8'hC4);
      chk("irq push only", {7'b0, bus.interrupt}, 8'h00);
      bus.interrupt_ack = 1'b1;
      bus.dout_ready    = 1'b1;
      tick();
      bus.interrupt_ack = 1'b0;
      bus.dout_ready    = 1'b0;
      chk("irq set beats ack", {7'b0, bus.interrupt}, 8'h01);
      rd("status irq", 8'h09, 8'h10);
      wr(8'h0B, 8'h02);
      chk("irq_en cleared", {7'b0, bus.interrupt}, 8'h00);
      pop1();
      pop1();
      chk("irq disabled drain", {7'b0, bus.interrupt}, 8'h00);
      chk("drain2 valid", {7'b0, bus.dout_valid}, 8'h00);
      wr(8'h0B, 8'h3F);
      rd("ctrl clamp", 8'h0B, 8'h0F);
      wr(8'h0B, 8'hC5);
      rd("ctrl flush bit", 8'h0B, 8'h85);
      wr(8'h0B, 8'h00);

      // Simultaneous push+pop at count 5, then order check.
      for (int i = 0; i < 5; i++) wr(8'h08, 8'(8'hB0 + i));
      rd("count 5", 8'h0A, 8'h05);
      bus.port_id      = 8'h08;
      bus.out_port     = 8'hB5;
      bus.write_strobe = 1'b1;
      bus.dout_ready   = 1'b1;
      tick();
      bus.write_strobe = 1'b0;
      bus.dout_ready   = 1'b0;
      rd("count pushpop", 8'h0A, 8'h05);
      for (int k = 1; k < 6; k++) begin
         chk($sformatf("order%0d dout", k), bus.dout, 8'(8'hB0 + k));
         pop1();
      end
      chk("order empty", {7'b0, bus.dout_valid}, 8'h00);

      // Flush with overflow pending and a concurrent pop.
      for (int i = 0; i < 17; i++) wr(8'h08, 8'(8'h60 + i));
      bus.port_id      = 8'h0B;
      bus.out_port     = 8'h40;
      bus.write_strobe = 1'b1;
      bus.dout_ready   = 1'b1;
      tick();
      bus.write_strobe = 1'b0;
      bus.dout_ready   = 1'b0;
      chk("flush valid", {7'b0, bus.dout_valid}, 8'h00);
      chk("flush dout", bus.dout, 8'h00);
      rd("flush count", 8'h0A, 8'h00);
      rd("flush status", 8'h09, 8'h60);

      // Asynchronous reset mid-cycle with count 7 and interrupt pending.
      wr(8'h0B, 8'h87);
      for (int i = 0; i < 8; i++) wr(8'h08, 8'(8'h70 + i));
      pop1();
      chk("pre-reset irq", {7'b0, bus.interrupt}, 8'h01);
      rd("pre-reset count", 8'h0A, 8'h07);
      #2 reset_n = 1'b0;
      #1;
      chk("arst in_port", bus.in_port, 8'h00);
      chk("arst interrupt", {7'b0, bus.interrupt}, 8'h00);
      chk("arst valid", {7'b0, bus.dout_valid}, 8'h00);
      chk("arst dout", bus.dout, 8'h00);
      #2 reset_n = 1'b1;
      tick();
      rd("post-reset count", 8'h0A, 8'h00);
      rd("post-reset status", 8'h09, 8'h40);
      rd("post-reset ctrl", 8'h0B, 8'h00);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
